// File: rtl/conv_pkg.sv
// Shared fixed-point helpers for the decoder's convolution layers: default
// Q-format, FSM state type, accumulator sizing and round/saturate.
package conv_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } conv_state_t;

    function automatic int acc_width(input int dw, input int taps);
        return 2 * dw + $clog2(taps) + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round half toward +inf, drop fb fraction bits, clamp to a dw-bit signed range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                     input int dw, input int fb,
                                                     input logic relu);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (fb > 0) begin
            r = (v + (64'sd1 <<< (fb - 1))) >>> fb;
        end else begin
            r = v;
        end
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end else begin
            r = r;
        end
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv1d_module_fxp_round_sat.sv
// Combinational accumulator -> DATA_WIDTH conversion: round, saturate and
// optionally clamp negatives to zero.
module fxp_round_sat
    import conv_pkg::*;
#(
    parameter int ACC_W      = 36,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter bit RELU_EN    = 1'b0
) (
    input  logic signed [ACC_W-1:0]      i_acc,
    output logic signed [DATA_WIDTH-1:0] o_y
);

    // Accumulator fits in 64 bits for every supported configuration.
    always_comb begin
        o_y = DATA_WIDTH'(round_sat(64'(i_acc), DATA_WIDTH, FRAC_BITS, RELU_EN));
    end

endmodule

// File: rtl/conv1d_module.sv
// Fixed-point 1-D "same"-padded, stride-1 convolution, one MAC per cycle,
// start/done-tick handshake matching the upsample stage.
module conv1d_module
    import conv_pkg::*;
#(
    parameter int IN_CH      = 2,
    parameter int OUT_CH     = 2,
    parameter int FRAMES     = 4,
    parameter int KERNEL     = 3,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter bit RELU_EN    = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic signed [DATA_WIDTH-1:0] i_data    [0:IN_CH-1][0:FRAMES-1],
    input  logic signed [DATA_WIDTH-1:0] i_weights [0:OUT_CH-1][0:IN_CH-1][0:KERNEL-1],
    input  logic signed [DATA_WIDTH-1:0] i_bias    [0:OUT_CH-1],
    output logic                         o_busy,
    output logic                         o_done_tick,
    output logic signed [DATA_WIDTH-1:0] o_result  [0:OUT_CH-1][0:FRAMES-1]
);

    localparam int PAD   = (KERNEL - 1) / 2;
    localparam int ACC_W = acc_width(DATA_WIDTH, IN_CH * KERNEL);
    localparam int OC_W  = cnt_width(OUT_CH);
    localparam int IC_W  = cnt_width(IN_CH);
    localparam int T_W   = cnt_width(FRAMES);
    localparam int K_W   = cnt_width(KERNEL);

    conv_state_t r_state;
    conv_state_t w_next_state;

    logic signed [DATA_WIDTH-1:0] r_data [0:IN_CH-1][0:FRAMES-1];
    logic signed [DATA_WIDTH-1:0] r_w    [0:OUT_CH-1][0:IN_CH-1][0:KERNEL-1];
    logic signed [DATA_WIDTH-1:0] r_bias [0:OUT_CH-1];
    logic signed [DATA_WIDTH-1:0] r_buf  [0:OUT_CH-1][0:FRAMES-1];
    logic signed [ACC_W-1:0]      r_acc;
    logic [OC_W-1:0]              r_oc;
    logic [IC_W-1:0]              r_ic;
    logic [T_W-1:0]               r_t;
    logic [K_W-1:0]               r_k;

    logic signed [31:0]             w_idx;
    logic signed [DATA_WIDTH-1:0]   w_x;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [DATA_WIDTH-1:0]   w_y;
    logic                           w_last_tap;
    logic                           w_last_out;
    logic [T_W-1:0]                 w_next_t;
    logic [OC_W-1:0]                w_next_oc;

    function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic signed [DATA_WIDTH-1:0] b);
        return ACC_W'(b) <<< FRAC_BITS;
    endfunction

    fxp_round_sat #(
        .ACC_W     (ACC_W),
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RELU_EN   (RELU_EN)
    ) u_round_sat (
        .i_acc(r_acc),
        .o_y  (w_y)
    );

    // Tap fetch with zero padding outside the frame, plus loop-end detection.
    always_comb begin
        w_idx = 32'(r_t) + 32'(r_k) - 32'(PAD);
        if ((w_idx >= 32'sd0) && (w_idx < $signed(32'(FRAMES)))) begin
            w_x = r_data[r_ic][w_idx[T_W-1:0]];
        end else begin
            w_x = {DATA_WIDTH{1'b0}};
        end
        w_prod     = w_x * r_w[r_oc][r_ic][r_k];
        w_last_tap = (r_ic == IC_W'(IN_CH - 1)) && (r_k == K_W'(KERNEL - 1));
        w_last_out = (r_oc == OC_W'(OUT_CH - 1)) && (r_t == T_W'(FRAMES - 1));
        if (r_t == T_W'(FRAMES - 1)) begin
            w_next_t  = {T_W{1'b0}};
            w_next_oc = w_last_out ? {OC_W{1'b0}} : r_oc + OC_W'(1);
        end else begin
            w_next_t  = r_t + T_W'(1);
            w_next_oc = r_oc;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = i_start ? S_MAC : S_IDLE;
            S_MAC:   w_next_state = w_last_tap ? S_WRITE : S_MAC;
            S_WRITE: w_next_state = w_last_out ? S_DONE : S_MAC;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch, MAC datapath, output buffer and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= {ACC_W{1'b0}};
            r_oc        <= {OC_W{1'b0}};
            r_ic        <= {IC_W{1'b0}};
            r_t         <= {T_W{1'b0}};
            r_k         <= {K_W{1'b0}};
            o_busy      <= 1'b0;
            o_done_tick <= 1'b0;
            for (int o = 0; o < OUT_CH; o++) begin
                r_bias[o] <= {DATA_WIDTH{1'b0}};
                for (int t = 0; t < FRAMES; t++) begin
                    r_buf[o][t]    <= {DATA_WIDTH{1'b0}};
                    o_result[o][t] <= {DATA_WIDTH{1'b0}};
                end
                for (int i = 0; i < IN_CH; i++) begin
                    for (int k = 0; k < KERNEL; k++) begin
                        r_w[o][i][k] <= {DATA_WIDTH{1'b0}};
                    end
                end
            end
            for (int i = 0; i < IN_CH; i++) begin
                for (int t = 0; t < FRAMES; t++) begin
                    r_data[i][t] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done_tick <= 1'b0;
                    if (i_start) begin
                        r_data <= i_data;
                        r_w    <= i_weights;
                        r_bias <= i_bias;
                        r_oc   <= {OC_W{1'b0}};
                        r_ic   <= {IC_W{1'b0}};
                        r_t    <= {T_W{1'b0}};
                        r_k    <= {K_W{1'b0}};
                        r_acc  <= bias_to_acc(i_bias[0]);
                        o_busy <= 1'b1;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_k == K_W'(KERNEL - 1)) begin
                        r_k  <= {K_W{1'b0}};
                        r_ic <= (r_ic == IC_W'(IN_CH - 1)) ? {IC_W{1'b0}} : r_ic + IC_W'(1);
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                S_WRITE: begin
                    r_buf[r_oc][r_t] <= w_y;
                    r_t              <= w_next_t;
                    r_oc             <= w_next_oc;
                    r_acc            <= bias_to_acc(r_bias[w_next_oc]);
                    if (w_last_out) begin
                        o_done_tick <= 1'b1;
                        for (int o = 0; o < OUT_CH; o++) begin
                            for (int t = 0; t < FRAMES; t++) begin
                                if ((OC_W'(o) == r_oc) && (T_W'(t) == r_t)) begin
                                    o_result[o][t] <= w_y;
                                end else begin
                                    o_result[o][t] <= r_buf[o][t];
                                end
                            end
                        end
                    end else begin
                        o_done_tick <= 1'b0;
                    end
                end
                S_DONE: begin
                    o_done_tick <= 1'b0;
                    o_busy      <= 1'b0;
                end
                default: begin
                    o_done_tick <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
